// File: rtl/job_arbiter_if.sv
// Requester/engine handshake bundle for job_arbiter.
// slave = arbiter side, master = requesters + engine side.
interface job_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0] req;
    logic [N-1:0] cancel;
    logic         eng_done;
    logic         eng_go;
    logic         eng_kill;
    logic [N-1:0] grant;
    logic [N-1:0] ack;
    logic [N-1:0] err;
    logic         busy;

    modport slave (
        input  req, cancel, eng_done,
        output eng_go, eng_kill, grant, ack, err, busy
    );

    modport master (
        output req, cancel, eng_done,
        input  eng_go, eng_kill, grant, ack, err, busy
    );
endinterface

// File: rtl/job_arbiter.sv
// Round-robin owner of a single go/kill/done engine, with a watchdog and owner cancel.
// Every output is a flop fed from the next-state values, so go/grant line up with state.
module job_arbiter #(
    parameter int N           = 4,
    parameter int TW          = 8,
    parameter int TIMEOUT     = 127,
    parameter int KILL_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    job_arbiter_if.slave bus
);
    localparam int PW  = (N > 1) ? $clog2(N) : 1;
    localparam int PW1 = PW + 1;
    localparam int KW  = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, KILL, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [KW-1:0] kcnt_q, kcnt_d;
    logic          go_q, go_d;
    logic          kill_q, kill_d;
    logic          busy_q, busy_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [N-1:0]  err_q, err_d;

    logic [N-1:0]   rot;
    logic [PW-1:0]  off, sel, nxt_ptr;
    logic [PW1-1:0] sum;
    logic           found;

    assign nxt_ptr = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            timer_q <= '0;
            kcnt_q  <= '0;
            go_q    <= 1'b0;
            kill_q  <= 1'b0;
            busy_q  <= 1'b0;
            grant_q <= '0;
            ack_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            kcnt_q  <= kcnt_d;
            go_q    <= go_d;
            kill_q  <= kill_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        kcnt_d  = kcnt_q;

        // Rotate so bit 0 is the pointer, pick the lowest set bit, rotate back.
        rot   = N'({bus.req, bus.req} >> ptr_q);
        off   = '0;
        found = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                off   = PW'(j);
            end
        end
        sum = PW1'(ptr_q) + PW1'(off);
        sel = (sum >= PW1'(N)) ? PW'(sum - PW1'(N)) : PW'(sum);

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = RUN;
                    owner_d = sel;
                    timer_d = '0;
                end
            end
            RUN: begin
                timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
                if (bus.eng_done) begin
                    state_d = IDLE;
                    ptr_d   = nxt_ptr;
                end else if (bus.cancel[owner_q] || timer_q == TW'(TIMEOUT)) begin
                    state_d = KILL;
                    kcnt_d  = '0;
                end
            end
            KILL: begin
                if (kcnt_q == KW'(KILL_CYCLES - 1)) state_d = DRAIN;
                else                                 kcnt_d  = kcnt_q + 1'b1;
            end
            DRAIN: begin
                state_d = IDLE;
                ptr_d   = nxt_ptr;
            end
            default: state_d = IDLE;
        endcase
    end

    // ack/err are registered off the leaving transition, so they show up as grant drops.
    always_comb begin
        go_d    = (state_q == IDLE) && (state_d == RUN);
        kill_d  = (state_d == KILL);
        busy_d  = (state_d != IDLE);
        grant_d = busy_d ? (N'(1) << owner_d) : '0;
        ack_d   = (state_q == RUN && bus.eng_done) ? (N'(1) << owner_q) : '0;
        err_d   = (state_q == DRAIN) ? (N'(1) << owner_q) : '0;
    end

    assign bus.eng_go   = go_q;
    assign bus.eng_kill = kill_q;
    assign bus.busy     = busy_q;
    assign bus.grant    = grant_q;
    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_job_arbiter.sv
// Bench for job_arbiter: directed jobs, ack/err responses checked against a scoreboard queue.
module tb_job_arbiter;
    localparam int N           = 4;
    localparam int TW          = 8;
    localparam int TIMEOUT     = 127;
    localparam int KILL_CYCLES = 2;

    logic clk;
    logic reset;

    job_arbiter_if #(.N(N)) bus ();

    job_arbiter #(
        .N(N), .TW(TW), .TIMEOUT(TIMEOUT), .KILL_CYCLES(KILL_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         is_err;
        logic [N-1:0] who;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_r;
    int    n_chk  = 0;
    int    n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic is_err, input logic [N-1:0] who);
        resp_t r;
        r.is_err = is_err;
        r.who    = who;
        exp_q.push_back(r);
    endtask

    task automatic wait_go(input string tag);
        int t = 0;
        while (!bus.eng_go && t < 20) begin
            tick();
            t++;
        end
        chk({tag, "_go_seen"}, 32'(bus.eng_go), 1);
    endtask

    // From the current negedge: wait L cycles, pulse eng_done for one cycle.
    task automatic finish_after(input int l);
        repeat (l) tick();
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
    endtask

    // Every ack/err pulse must match the next scoreboard entry and arrive with grant low.
    always @(negedge clk) begin
        if (!reset && (bus.ack != '0 || bus.err != '0)) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 32'({bus.ack, bus.err}), 0);
            end else begin
                mon_r = exp_q.pop_front();
                chk("resp_who", 32'({bus.ack, bus.err}),
                    mon_r.is_err ? 32'({{N{1'b0}}, mon_r.who}) : 32'({mon_r.who, {N{1'b0}}}));
                chk("resp_grant_low", 32'(bus.grant), 0);
            end
        end
    end

    initial begin
        logic [N-1:0] g;
        int t;
        reset        = 1'b1;
        bus.req      = '0;
        bus.cancel   = '0;
        bus.eng_done = 1'b0;
        repeat (3) tick();
        chk("rst_outs", 32'({bus.eng_go, bus.eng_kill, bus.busy, bus.grant, bus.ack, bus.err}), 0);
        reset = 1'b0;
        tick();

        // basic job, 103-cycle engine
        bus.req = 4'b0010;
        wait_go("basic");
        chk("basic_grant", 32'(bus.grant), 32'b0010);
        chk("basic_busy", 32'(bus.busy), 1);
        bus.req = '0;
        push(1'b0, 4'b0010);
        tick();
        chk("basic_go_1cyc", 32'(bus.eng_go), 0);
        finish_after(102);
        chk("basic_idle_busy", 32'(bus.busy), 0);
        tick();
        // ptr should now be 2: 0101 must pick requester 2
        bus.req = 4'b0101;
        wait_go("ptr2");
        chk("ptr2_grant", 32'(bus.grant), 32'b0100);
        bus.req = '0;
        push(1'b0, 4'b0100);
        finish_after(10);
        tick();

        // round-robin with all requesting, ptr back to 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g = N'(1) << (k % N);
            if (k == 0) wait_go("rr");
            else        chk("rr_gap_go", 32'(bus.eng_go), 1);
            chk("rr_grant", 32'(bus.grant), 32'(g));
            push(1'b0, g);
            finish_after(10);
            if (k == 4) bus.req = '0;
            chk("rr_idle_busy", 32'(bus.busy), 0);
            tick();
        end

        // watchdog, engine silent
        bus.req = 4'b0001;
        wait_go("wd");
        bus.req = '0;
        t = 0;
        while (!bus.eng_kill && t < 300) begin
            tick();
            t++;
        end
        chk("wd_kill_start", 32'(t), 128);
        push(1'b1, 4'b0001);
        tick();
        chk("wd_kill_2nd", 32'(bus.eng_kill), 1);
        tick();
        chk("wd_drain_kill_low", 32'(bus.eng_kill), 0);
        chk("wd_drain_grant", 32'(bus.grant), 32'b0001);
        tick();
        chk("wd_idle_busy", 32'(bus.busy), 0);
        tick();

        // owner cancel at RUN cycle 20 (ptr=1)
        bus.req = 4'b0010;
        wait_go("can");
        chk("can_grant", 32'(bus.grant), 32'b0010);
        bus.req = '0;
        repeat (20) tick();
        bus.cancel = 4'b0010;
        push(1'b1, 4'b0010);
        tick();
        bus.cancel = '0;
        chk("can_kill", 32'(bus.eng_kill), 1);
        repeat (3) tick();
        chk("can_idle_busy", 32'(bus.busy), 0);
        tick();

        // non-owner cancel ignored (ptr=2)
        bus.req = 4'b0100;
        wait_go("nown");
        chk("nown_grant", 32'(bus.grant), 32'b0100);
        bus.req = '0;
        push(1'b0, 4'b0100);
        repeat (20) tick();
        bus.cancel = 4'b1011;
        repeat (3) begin
            tick();
            chk("nown_no_kill", 32'(bus.eng_kill), 0);
        end
        bus.cancel = '0;
        finish_after(5);
        chk("nown_idle_busy", 32'(bus.busy), 0);
        tick();

        // reset during KILL (ptr=3, owner 3)
        bus.req = 4'b1000;
        wait_go("rm");
        bus.req = '0;
        repeat (2) tick();
        bus.cancel = 4'b1000;
        tick();
        bus.cancel = '0;
        chk("rm_in_kill", 32'(bus.eng_kill), 1);
        reset = 1'b1;
        #1;
        chk("rm_async", 32'({bus.eng_kill, bus.grant, bus.busy}), 0);
        tick();
        reset = 1'b0;
        tick();
        // old ptr 3 would pick 1000; restarted ptr 0 picks 0001
        bus.req = 4'b1001;
        wait_go("rm_post");
        chk("rm_post_grant", 32'(bus.grant), 32'b0001);
        bus.req = '0;
        push(1'b0, 4'b0001);
        finish_after(5);
        tick();

        // done and owner cancel in the same cycle (ptr=1)
        bus.req = 4'b1000;
        wait_go("sim");
        chk("sim_grant", 32'(bus.grant), 32'b1000);
        bus.req = '0;
        push(1'b0, 4'b1000);
        repeat (5) tick();
        bus.eng_done = 1'b1;
        bus.cancel   = 4'b1000;
        tick();
        bus.eng_done = 1'b0;
        bus.cancel   = '0;
        chk("sim_no_kill", 32'(bus.eng_kill), 0);
        chk("sim_idle_busy", 32'(bus.busy), 0);
        tick();
        chk("sim_no_kill_later", 32'(bus.eng_kill), 0);
        tick();

        // stray done in IDLE
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        repeat (3) begin
            chk("stray_quiet",
                32'({bus.eng_go, bus.eng_kill, bus.busy, bus.grant, bus.ack, bus.err}), 0);
            tick();
        end

        repeat (3) tick();
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
